// File: rtl/irom_fetch_arbiter_if.sv
// ----------------------------------------------------------------------------
// irom_fetch_arbiter_if
//
// Bundles every handshake/bus signal of the instruction-ROM fetch arbiter:
// the IF fetch port, the MEM-stage load (LS) port and the shared ROM port.
//
// Signals:
//   if_req/if_addr      -> IF fetch request and byte address
//   if_valid/if_rdata   <- IF completion pulse and fetched word
//   stall_if            <- IF stalled (request pending, no valid yet)
//   ls_req/ls_addr      -> load-side request and byte address
//   ls_valid/ls_rdata   <- load-side completion pulse and word
//   read_ce/irom_addr   <- ROM read enable and word address
//   rom_inst/irom_fin   -> ROM read data and completion strobe
//   err                 <- timeout flag, pulses with the completing valid
//
// Modports:
//   master : the arbiter's view
//   slave  : the environment's view (requesters plus ROM)
// ----------------------------------------------------------------------------
interface irom_fetch_arbiter_if;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_valid;
    logic [31:0] if_rdata;
    logic        stall_if;

    logic        ls_req;
    logic [31:0] ls_addr;
    logic        ls_valid;
    logic [31:0] ls_rdata;

    logic        read_ce;
    logic [29:0] irom_addr;
    logic [31:0] rom_inst;
    logic        irom_fin;
    logic        err;

    modport master (
        input  if_req, if_addr, ls_req, ls_addr, rom_inst, irom_fin,
        output if_valid, if_rdata, stall_if, ls_valid, ls_rdata,
               read_ce, irom_addr, err
    );

    modport slave (
        output if_req, if_addr, ls_req, ls_addr, rom_inst, irom_fin,
        input  if_valid, if_rdata, stall_if, ls_valid, ls_rdata,
               read_ce, irom_addr, err
    );
endinterface

// File: rtl/irom_fetch_arbiter.sv
// ----------------------------------------------------------------------------
// irom_fetch_arbiter
//
// Arbitrates the single instruction-ROM read port between the IF stage fetch
// and the MEM-stage load path (read-only constants). One request is granted
// per IDLE cycle, the ROM handshake is run in BUSY, and the returned word is
// presented to the owner for one cycle in RESP.
//
// Ports:
//   clk    : clock, rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : irom_fetch_arbiter_if.master (requester ports and ROM port)
//
// Parameters:
//   STARVE_MAX : consecutive LS grants allowed while IF waits
//   TIMEOUT    : BUSY cycles without irom_fin before giving up
//                (only with IROM_TIMEOUT_EN)
//
// Configuration macro:
//   IROM_TIMEOUT_EN : when defined, a stuck ROM read is abandoned after
//                     TIMEOUT BUSY cycles, returning a NOP with err = 1.
//                     When undefined, BUSY waits forever and err is 0.
// ----------------------------------------------------------------------------
module irom_fetch_arbiter #(
    parameter int STARVE_MAX = 4,
    parameter int TIMEOUT    = 64
) (
    input  logic                         clk,
    input  logic                         rst_n,
    irom_fetch_arbiter_if.master         bus
);

    if (STARVE_MAX < 1 || TIMEOUT < 1) begin : g_param_check
        $error("irom_fetch_arbiter: STARVE_MAX and TIMEOUT must be >= 1");
    end

    localparam int SC_W = $clog2(STARVE_MAX + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t          state_q;
    logic            owner_ls_q;   // 1: LS owns the transaction, 0: IF
    logic [29:0]     addr_q;       // word address; byte offset is ignored
    logic [SC_W-1:0] starve_cnt;
    logic            read_ce_q;
    logic            if_valid_q;
    logic            ls_valid_q;
    logic [31:0]     if_rdata_q;
    logic [31:0]     ls_rdata_q;

    logic            grant_ls;
    logic            grant_if;
    logic            starved;
    logic            busy_done;
    logic [31:0]     resp_data;

    // IF wins only once LS has been granted STARVE_MAX times in a row
    // while IF was waiting.
    assign starved  = (starve_cnt == SC_W'(STARVE_MAX));
    assign grant_ls = bus.ls_req && !(bus.if_req && starved);
    assign grant_if = bus.if_req && !grant_ls;

    // A timed-out read returns zero (NOP); a real completion always wins.
    assign resp_data = bus.irom_fin ? bus.rom_inst : 32'h0000_0000;

`ifdef IROM_TIMEOUT_EN
    localparam int TC_W = $clog2(TIMEOUT + 1);

    logic [TC_W-1:0] busy_cnt;
    logic            timed_out;
    logic            err_q;

    // busy_cnt counts completed BUSY cycles, so the current cycle is the
    // TIMEOUT-th one when it equals TIMEOUT-1.
    assign timed_out = (busy_cnt == TC_W'(TIMEOUT - 1));
    assign busy_done = bus.irom_fin || timed_out;
    assign bus.err   = err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_cnt <= '0;
            err_q    <= 1'b0;
        end else begin
            err_q <= 1'b0;
            if (state_q == IDLE) begin
                busy_cnt <= '0;
            end else if (state_q == BUSY) begin
                if (busy_done) begin
                    err_q <= !bus.irom_fin;
                end else begin
                    busy_cnt <= busy_cnt + 1'b1;
                end
            end
        end
    end
`else
    assign busy_done = bus.irom_fin;
    assign bus.err   = 1'b0;
`endif

    // NOTE: all state below is updated with non-blocking assignments so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            owner_ls_q <= 1'b0;
            addr_q     <= '0;
            starve_cnt <= '0;
            read_ce_q  <= 1'b0;
            if_valid_q <= 1'b0;
            ls_valid_q <= 1'b0;
            if_rdata_q <= '0;
            ls_rdata_q <= '0;
        end else begin
            if_valid_q <= 1'b0;
            ls_valid_q <= 1'b0;

            unique case (state_q)
                IDLE: begin
                    if (grant_ls || grant_if) begin
                        owner_ls_q <= grant_ls;
                        addr_q     <= grant_ls ? bus.ls_addr[31:2] : bus.if_addr[31:2];
                        read_ce_q  <= 1'b1;
                        state_q    <= BUSY;
                        if (grant_ls && bus.if_req) begin
                            starve_cnt <= starved ? starve_cnt : starve_cnt + 1'b1;
                        end else begin
                            starve_cnt <= '0;
                        end
                    end
                end

                BUSY: begin
                    if (busy_done) begin
                        read_ce_q <= 1'b0;
                        state_q   <= RESP;
                        if (owner_ls_q) begin
                            ls_valid_q <= 1'b1;
                            ls_rdata_q <= resp_data;
                        end else begin
                            if_valid_q <= 1'b1;
                            if_rdata_q <= resp_data;
                        end
                    end
                end

                RESP: begin
                    state_q <= IDLE;
                end

                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.read_ce   = read_ce_q;
    assign bus.irom_addr = addr_q;
    assign bus.if_valid  = if_valid_q;
    assign bus.ls_valid  = ls_valid_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.ls_rdata  = ls_rdata_q;
    assign bus.stall_if  = bus.if_req && !if_valid_q;

endmodule

// File: tb/tb_irom_fetch_arbiter.sv
// ----------------------------------------------------------------------------
// tb_irom_fetch_arbiter
//
// Directed bench for irom_fetch_arbiter. A ROM responder answers read_ce after
// a programmable number of BUSY cycles; every issued request pushes its
// expected owner/data/err onto a scoreboard queue that a monitor pops on each
// valid pulse. Steps: reset values, single IF fetch, simultaneous requests,
// starvation override, reset during BUSY, long ROM wait (or timeout when
// IROM_TIMEOUT_EN is defined).
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_irom_fetch_arbiter;

    localparam int STARVE_MAX = 4;
    localparam int TIMEOUT    = 64;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    irom_fetch_arbiter_if bus ();

    irom_fetch_arbiter #(
        .STARVE_MAX (STARVE_MAX),
        .TIMEOUT    (TIMEOUT)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct packed {
        logic        ls;
        logic [31:0] data;
        logic        err;
    } exp_t;

    exp_t sb[$];
    int   errors    = 0;
    int   checks    = 0;
    int   fin_delay = 0;   // BUSY cycle (1-based) in which the ROM answers; 0 = never
    int   busy_n    = 0;
    logic fin_force = 1'b0;

    // Reference ROM contents.
    function automatic logic [31:0] rom_word(input logic [29:0] a);
        if (a == 30'h4) return 32'h2002_0005;
        return {2'b01, a} ^ 32'h0F0F_5A5A;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // All directed driving and checking happens 1ns after the falling edge.
    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_valid(input logic ls, input int budget, output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (!(ls ? bus.ls_valid : bus.if_valid) && n < budget);
        check(ls ? "ls_valid_seen" : "if_valid_seen",
              32'(ls ? bus.ls_valid : bus.if_valid), 32'd1);
    endtask

    // ROM responder.
    always @(negedge clk) begin
        if (bus.read_ce) busy_n = busy_n + 1;
        else             busy_n = 0;
        if (fin_force) begin
            bus.irom_fin = 1'b1;
            bus.rom_inst = 32'hDEAD_BEEF;
        end else if (bus.read_ce && fin_delay != 0 && busy_n == fin_delay) begin
            bus.irom_fin = 1'b1;
            bus.rom_inst = rom_word(bus.irom_addr);
        end else begin
            bus.irom_fin = 1'b0;
            bus.rom_inst = 'x;
        end
    end

    // Scoreboard monitor.
    always @(negedge clk) begin
        exp_t e;
        if (bus.if_valid || bus.ls_valid) begin
            if (sb.size() == 0) begin
                check("unexpected_valid", {30'b0, bus.ls_valid, bus.if_valid}, 32'd0);
            end else begin
                e = sb.pop_front();
                check("valid_owner", {30'b0, bus.ls_valid, bus.if_valid}, e.ls ? 32'd2 : 32'd1);
                check("rdata", e.ls ? bus.ls_rdata : bus.if_rdata, e.data);
                check("err", 32'(bus.err), 32'(e.err));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        int bad;

        rst_n       = 1'b0;
        bus.if_req  = 1'b0;
        bus.if_addr = '0;
        bus.ls_req  = 1'b0;
        bus.ls_addr = '0;
        repeat (2) step();

        // Reset values.
        check("rst_read_ce",   32'(bus.read_ce),   32'd0);
        check("rst_irom_addr", 32'(bus.irom_addr), 32'd0);
        check("rst_if_valid",  32'(bus.if_valid),  32'd0);
        check("rst_ls_valid",  32'(bus.ls_valid),  32'd0);
        check("rst_err",       32'(bus.err),       32'd0);
        check("rst_if_rdata",  bus.if_rdata,       32'd0);
        check("rst_ls_rdata",  bus.ls_rdata,       32'd0);
        check("rst_stall_if",  32'(bus.stall_if),  32'd0);
        rst_n = 1'b1;
        step();

        // Single IF fetch, ROM answers in the first BUSY cycle.
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h0000_0010;
        fin_delay   = 1;
        sb.push_back('{ls: 1'b0, data: 32'h2002_0005, err: 1'b0});
        #1;
        check("t1_stall_req", 32'(bus.stall_if), 32'd1);
        step();
        check("t1_read_ce",   32'(bus.read_ce),   32'd1);
        check("t1_irom_addr", 32'(bus.irom_addr), 32'h4);
        check("t1_no_valid",  32'(bus.if_valid),  32'd0);
        check("t1_stall",     32'(bus.stall_if),  32'd1);
        step();
        check("t1_if_valid",  32'(bus.if_valid),  32'd1);
        check("t1_ls_quiet",  32'(bus.ls_valid),  32'd0);
        check("t1_stall_off", 32'(bus.stall_if),  32'd0);
        bus.if_req = 1'b0;
        step();
        check("t1_pulse_once", 32'(bus.if_valid), 32'd0);
        check("t1_ce_off",     32'(bus.read_ce),  32'd0);
        check("t1_rdata_hold", bus.if_rdata,      32'h2002_0005);

        // Simultaneous requests: LS first, then IF.
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h0000_0100;
        bus.ls_req  = 1'b1;
        bus.ls_addr = 32'h0000_0200;
        sb.push_back('{ls: 1'b1, data: rom_word(30'h80), err: 1'b0});
        sb.push_back('{ls: 1'b0, data: rom_word(30'h40), err: 1'b0});
        step();
        check("t2_ls_addr", 32'(bus.irom_addr), 32'h80);
        wait_valid(1'b1, 5, n);
        bus.ls_req = 1'b0;
        step();
        step();
        check("t2_if_ce",   32'(bus.read_ce),   32'd1);
        check("t2_if_addr", 32'(bus.irom_addr), 32'h40);
        wait_valid(1'b0, 5, n);
        bus.if_req = 1'b0;
        step();

        // Starvation: LS held with fresh addresses, IF held.
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h0000_0300;
        bus.ls_req  = 1'b1;
        bus.ls_addr = 32'h0000_1000;
        for (int k = 0; k < STARVE_MAX; k++) begin
            sb.push_back('{ls: 1'b1, data: rom_word(30'(32'h400 + k)), err: 1'b0});
        end
        sb.push_back('{ls: 1'b0, data: rom_word(30'hC0), err: 1'b0});
        sb.push_back('{ls: 1'b1, data: rom_word(30'(32'h400 + STARVE_MAX)), err: 1'b0});
        for (int k = 0; k < STARVE_MAX + 2; k++) begin
            n = 0;
            do begin
                step();
                n++;
            end while (!(bus.if_valid || bus.ls_valid) && n < 6);
            check("t3_progress", 32'(bus.if_valid || bus.ls_valid), 32'd1);
            if (bus.ls_valid) bus.ls_addr = bus.ls_addr + 32'd4;
            if (bus.if_valid) bus.if_req  = 1'b0;
        end
        bus.ls_req = 1'b0;
        step();
        step();
        check("t3_sb_drained", 32'(sb.size()), 32'd0);

        // Reset asserted while BUSY; a later irom_fin must be ignored.
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h0000_0040;
        fin_delay   = 0;
        step();
        check("t4_busy", 32'(bus.read_ce), 32'd1);
        step();
        rst_n      = 1'b0;
        bus.if_req = 1'b0;
        #1;
        check("t4_rst_ce",     32'(bus.read_ce),   32'd0);
        check("t4_rst_addr",   32'(bus.irom_addr), 32'd0);
        check("t4_rst_ifd",    bus.if_rdata,       32'd0);
        check("t4_rst_lsd",    bus.ls_rdata,       32'd0);
        check("t4_rst_valids", {30'b0, bus.ls_valid, bus.if_valid}, 32'd0);
        step();
        rst_n = 1'b1;
        fin_force = 1'b1;
        step();
        fin_force = 1'b0;
        bad = 0;
        repeat (3) begin
            step();
            if (bus.read_ce || bus.if_valid || bus.ls_valid || bus.err) bad++;
        end
        check("t4_fin_ignored", 32'(bad), 32'd0);

`ifdef IROM_TIMEOUT_EN
        // ROM never answers: NOP with err after TIMEOUT BUSY cycles.
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h0000_0084;
        fin_delay   = 0;
        sb.push_back('{ls: 1'b0, data: 32'h0, err: 1'b1});
        step();
        wait_valid(1'b0, TIMEOUT + 16, n);
        check("t5_timeout_latency", 32'(n), 32'(TIMEOUT));
        check("t5_err", 32'(bus.err), 32'd1);
        bus.if_req = 1'b0;
        step();
        check("t5_err_pulse", 32'(bus.err), 32'd0);

        // irom_fin in the same cycle the counter expires wins.
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h0000_0088;
        fin_delay   = TIMEOUT;
        sb.push_back('{ls: 1'b0, data: rom_word(30'h22), err: 1'b0});
        step();
        wait_valid(1'b0, TIMEOUT + 16, n);
        check("t5_fin_wins_latency", 32'(n), 32'(TIMEOUT));
        bus.if_req = 1'b0;
        step();
`else
        // ROM silent for 200 BUSY cycles, answers in the 201st.
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h0000_0084;
        fin_delay   = 201;
        sb.push_back('{ls: 1'b0, data: rom_word(30'h21), err: 1'b0});
        bad = 0;
        for (int c = 0; c < 200; c++) begin
            step();
            if (!bus.read_ce || bus.if_valid || bus.ls_valid || bus.err) bad++;
        end
        check("t5_long_wait_hold", 32'(bad), 32'd0);
        wait_valid(1'b0, 5, n);
        check("t5_long_wait_latency", 32'(n), 32'd2);
        bus.if_req = 1'b0;
        step();
`endif

        step();
        check("final_sb_empty", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
